// File: rtl/asteroid_controller.sv
// asteroid_controller: owns one asteroid's position. It spawns the asteroid
// at a pseudo-random column, drops it down the screen once per movement
// tick, and retires it on a hit or when it reaches the bottom. After a
// respawn delay it spawns the asteroid again.
// Pulse outputs (asteroid_hit, asteroid_missed, respawn) are registered and
// are high for exactly one clock. Only one of them is high in any cycle.
// A decision made in cycle N appears on the outputs in cycle N+1.
module asteroid_controller #(
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120,
    parameter int AST_W         = 8,
    parameter int AST_H         = 9,
    parameter int TICK_DIV      = 833333,
    parameter int STEP          = 1,
    parameter int RESPAWN_TICKS = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       destroyasteroid,
    input  logic       gameover,
    output logic [7:0] asteroidx,
    output logic [6:0] asteroidy,
    output logic       asteroid_active,
    output logic       asteroid_hit,
    output logic       asteroid_missed,
    output logic       respawn,
    output logic [2:0] o_dbg_state,
    output logic [7:0] o_dbg_lfsr
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS + 1) : 1;
    localparam int X_MAX  = SCREEN_W - AST_W;
    localparam int Y_MAX  = SCREEN_H - AST_H;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_WAIT  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [7:0]         r_lfsr;
    logic               r_start_q;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_nx;
    logic [7:0]         r_x;
    logic [7:0]         w_x_nx;
    logic [6:0]         r_y;
    logic [6:0]         w_y_nx;
    logic               r_active;
    logic               w_active_nx;
    logic               r_hit;
    logic               w_hit_nx;
    logic               r_missed;
    logic               w_missed_nx;
    logic               r_respawn;
    logic               w_respawn_nx;

    logic               w_tick;
    logic               w_start_rise;
    logic               w_lfsr_fb;
    logic [7:0]         w_col;
    logic [7:0]         w_y_sum;

    assign w_tick       = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    assign w_start_rise = start & ~r_start_q;
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Fold LFSR values past the last legal column back into range.
    assign w_col        = (r_lfsr <= 8'(X_MAX)) ? r_lfsr : (r_lfsr - 8'(X_MAX + 1));
    // Nine bits of headroom are not needed; eight bits keep y+STEP from wrapping.
    assign w_y_sum      = {1'b0, r_y} + 8'(STEP);

    // Free-running movement tick divider, LFSR and start edge register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
            r_lfsr     <= 8'hA5;
            r_start_q  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + CNT_W'(1));
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            r_start_q  <= start;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_active  <= 1'b0;
            r_hit     <= 1'b0;
            r_missed  <= 1'b0;
            r_respawn <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_wait    <= w_wait_nx;
            r_x       <= w_x_nx;
            r_y       <= w_y_nx;
            r_active  <= w_active_nx;
            r_hit     <= w_hit_nx;
            r_missed  <= w_missed_nx;
            r_respawn <= w_respawn_nx;
        end
    end

    // Next-state and next-output decisions. Within S_FALL the priority is gameover > hit > tick.
    always_comb begin
        w_state_nx   = r_state;
        w_wait_nx    = r_wait;
        w_x_nx       = r_x;
        w_y_nx       = r_y;
        w_active_nx  = r_active;
        w_hit_nx     = 1'b0;
        w_missed_nx  = 1'b0;
        w_respawn_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) w_state_nx = S_SPAWN;
            end
            S_SPAWN: begin
                w_x_nx       = w_col;
                w_y_nx       = '0;
                w_active_nx  = 1'b1;
                w_respawn_nx = 1'b1;
                w_wait_nx    = '0;
                w_state_nx   = S_FALL;
            end
            S_FALL: begin
                if (gameover) begin
                    w_state_nx = S_OVER;
                end else if (destroyasteroid) begin
                    w_hit_nx    = 1'b1;
                    w_active_nx = 1'b0;
                    w_wait_nx   = '0;
                    w_state_nx  = S_WAIT;
                end else if (w_tick) begin
                    if (w_y_sum > 8'(Y_MAX)) begin
                        w_missed_nx = 1'b1;
                        w_active_nx = 1'b0;
                        w_wait_nx   = '0;
                        w_state_nx  = S_WAIT;
                    end else begin
                        w_y_nx = w_y_sum[6:0];
                    end
                end
            end
            S_WAIT: begin
                w_active_nx = 1'b0;
                if (gameover) begin
                    w_state_nx = S_OVER;
                end else if (w_tick) begin
                    if (r_wait == WAIT_W'(RESPAWN_TICKS - 1)) w_state_nx = S_SPAWN;
                    else w_wait_nx = r_wait + WAIT_W'(1);
                end
            end
            S_OVER: begin
                if (w_start_rise) w_state_nx = S_SPAWN;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign asteroidx       = r_x;
    assign asteroidy       = r_y;
    assign asteroid_active = r_active;
    assign asteroid_hit    = r_hit;
    assign asteroid_missed = r_missed;
    assign respawn         = r_respawn;
    assign o_dbg_state     = r_state;
    assign o_dbg_lfsr      = r_lfsr;

endmodule
